// File: rtl/payload_engine_ctrl.sv
// Sequencer between a byte-stream payload port and a bank of sticky matching engines:
// clears the bank, streams bytes into it, flushes the pipeline and reports the lowest matching engine.
`timescale 1ns/1ps
module payload_engine_ctrl #(
  parameter int NUM_ENGINES  = 32,
  parameter int IDX_W        = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_sof,
  input  logic                   in_eof,
  output logic                   eng_sod,
  output logic                   eng_en,
  output logic [7:0]             eng_char,
  output logic                   eng_flush,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_hit,
  output logic [IDX_W-1:0]       res_idx,
  output logic [15:0]            res_len,
  output logic                   res_err
);

  // state  | meaning
  // IDLE   | waiting for a start-of-packet beat; non-sof beats are accepted and dropped
  // CLEAR  | one-cycle eng_sod pulse to the engine bank, byte counter zeroed
  // SCAN   | streaming accepted bytes to the engines
  // DRAIN  | DRAIN_CYCLES flush-enable cycles, then one cycle to sample eng_match
  // REPORT | result held on res_* until res_ready
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, REPORT} state_t;

  state_t           state_q;
  logic             sod_q;
  logic             en_q;
  logic             flush_q;
  logic [7:0]       char_q;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             err_q;
  logic [3:0]       dcnt_q;
  logic             res_valid_q;
  logic             res_hit_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [15:0]      res_len_q;
  logic             res_err_q;

  logic             sof_err;
  logic             accept;
  logic [IDX_W-1:0] low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (eng_match[i]) low_idx = IDX_W'(i);
    end
  end

  // A second sof once bytes have been counted belongs to the next packet: refuse it.
  assign sof_err = (state_q == SCAN) && in_valid && in_sof && (cnt_q != 16'd0);
  assign accept  = (state_q == SCAN) && in_valid && !sof_err;
  assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = in_valid && !in_sof;
      SCAN:    in_ready = !sof_err;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sod_q       <= 1'b1;
      en_q        <= 1'b0;
      flush_q     <= 1'b0;
      char_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      dcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_len_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      sod_q   <= 1'b0;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_sof) begin
            state_q <= CLEAR;
            sod_q   <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        CLEAR: state_q <= SCAN;
        SCAN: begin
          if (sof_err) begin
            err_q   <= 1'b1;
            state_q <= DRAIN;
            dcnt_q  <= 4'(DRAIN_CYCLES);
          end else if (accept) begin
            en_q   <= 1'b1;
            char_q <= in_data;
            cnt_q  <= cnt_d;
            if (in_eof) begin
              state_q <= DRAIN;
              dcnt_q  <= 4'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          // After the last flush-enable cycle, wait one more cycle so the engines' end state has latched.
          if (dcnt_q != 4'd0) begin
            en_q    <= 1'b1;
            flush_q <= 1'b1;
            dcnt_q  <= dcnt_q - 4'd1;
          end else if (!flush_q) begin
            res_hit_q   <= |eng_match;
            res_idx_q   <= low_idx;
            res_len_q   <= cnt_q;
            res_err_q   <= err_q;
            res_valid_q <= 1'b1;
            state_q     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_sod   = sod_q;
  assign eng_en    = en_q;
  assign eng_flush = flush_q;
  assign eng_char  = char_q;
  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_idx   = res_idx_q;
  assign res_len   = res_len_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Bench for payload_engine_ctrl: directed scenarios plus randomized packets against a packet-level reference model.
`timescale 1ns/1ps
module tb_payload_engine_ctrl;
  localparam int NE = 32;
  localparam int IW = 5;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sof, in_eof;
  logic [7:0]    in_data;
  logic          eng_sod, eng_en, eng_flush;
  logic [7:0]    eng_char;
  logic [NE-1:0] eng_match;
  logic          res_valid, res_ready, res_hit, res_err;
  logic [IW-1:0] res_idx;
  logic [15:0]   res_len;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pkt_q[$];
  logic [7:0] chars_q[$];
  int flushes = 0, sods = 0, excl_viol = 0, rv_seen = 0;
  logic          r_ok, r_hit, r_err;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_len;

  always #5 clk = ~clk;

  payload_engine_ctrl #(.NUM_ENGINES(NE), .IDX_W(IW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .eng_sod(eng_sod), .eng_en(eng_en), .eng_char(eng_char), .eng_flush(eng_flush), .eng_match(eng_match),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
    .res_len(res_len), .res_err(res_err)
  );

  // engine-side observer: characters delivered, flush cycles, clear pulses
  always @(negedge clk) begin
    if (eng_en && !eng_flush) chars_q.push_back(eng_char);
    if (eng_en && eng_flush) flushes++;
    if (eng_sod) sods++;
    if (eng_sod && eng_en) excl_viol++;
    if (res_valid) rv_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] ref_idx(input logic [31:0] m);
    logic [31:0] lo;
    logic [IW-1:0] r;
    lo = m & (~m + 32'd1);
    r = '0;
    for (int b = 0; b < 32; b++) if (lo[b]) r = IW'(b);
    return r;
  endfunction

  function automatic int char_diffs();
    int d;
    d = 0;
    if (chars_q.size() != pkt_q.size()) return 1000 + chars_q.size();
    for (int i = 0; i < pkt_q.size(); i++) if (chars_q[i] !== pkt_q[i]) d++;
    return d;
  endfunction

  task automatic clear_mon();
    @(negedge clk);
    flushes = 0; sods = 0; excl_viol = 0; rv_seen = 0;
    chars_q.delete();
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int budget;
    logic done;
    budget = 0; done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
    while (!done) begin
      #1;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else if (budget > 300) begin
        vectors++; miscompares++;
        $display("FAIL send_beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, budget);
        done = 1'b1;
      end else begin
        budget++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_gap(input int g);
    if (g > 0) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      repeat (g - 1) @(negedge clk);
    end
  endtask

  task automatic send_packet(input logic [31:0] m, input int gapmax);
    eng_match = '0;
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (gapmax > 0 && i > 0) idle_gap($urandom_range(0, gapmax));
      send_beat(pkt_q[i], i == 0, i == pkt_q.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    eng_match = m;
  endtask

  task automatic get_result(input int dly);
    int budget;
    budget = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (res_valid !== 1'b1) begin
      miscompares++; r_ok = 1'b0;
      $display("FAIL res_valid_timeout: res_valid=%b after %0d cycles, required 1", res_valid, budget);
    end else begin
      r_ok = 1'b1; r_hit = res_hit; r_idx = res_idx; r_len = res_len; r_err = res_err;
      repeat (dly) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = '0;
    res_ready = 1'b0; eng_match = '0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (eng_sod !== 1'b1) begin
      miscompares++; $display("FAIL reset_sod: eng_sod=%b, required 1", eng_sod);
    end
    vectors++;
    if ({in_ready, eng_en, eng_flush, res_valid, res_hit, res_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: {in_ready,eng_en,eng_flush,res_valid,res_hit,res_err}=%b, required 000000",
               {in_ready, eng_en, eng_flush, res_valid, res_hit, res_err});
    end
    vectors++;
    if ({res_idx, res_len, eng_char} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: res_idx=%0d res_len=%0d eng_char=%0h, required all 0", res_idx, res_len, eng_char);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abcd();
    pkt_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    clear_mon();
    send_packet(32'h0000_0100, 0);
    get_result(0);
    vectors++;
    if (sods !== 1) begin miscompares++; $display("FAIL abcd_sod: pulses=%0d, required 1", sods); end
    vectors++;
    if (char_diffs() !== 0) begin miscompares++; $display("FAIL abcd_chars: diffs=%0d, required 0", char_diffs()); end
    vectors++;
    if (flushes !== DC) begin miscompares++; $display("FAIL abcd_flush: cycles=%0d, required %0d", flushes, DC); end
    vectors++;
    if ({r_hit, r_idx, r_len, r_err} !== {1'b1, 5'd8, 16'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL abcd_result: hit=%b idx=%0d len=%0d err=%b, required 1 8 4 0", r_hit, r_idx, r_len, r_err);
    end
  endtask

  task automatic test_single();
    pkt_q = '{8'h5A};
    clear_mon();
    send_packet(32'h0, 0);
    get_result(1);
    vectors++;
    if ({r_hit, r_idx, r_len, r_err} !== {1'b0, 5'd0, 16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_result: hit=%b idx=%0d len=%0d err=%b, required 0 0 1 0", r_hit, r_idx, r_len, r_err);
    end
    vectors++;
    if (char_diffs() !== 0) begin miscompares++; $display("FAIL single_chars: diffs=%0d, required 0", char_diffs()); end
  endtask

  task automatic test_lowest_idx();
    pkt_q = '{8'h10, 8'h20, 8'h30};
    clear_mon();
    send_packet(32'h8000_0006, 1);
    get_result(2);
    vectors++;
    if ({r_hit, r_idx, r_len} !== {1'b1, 5'd1, 16'd3}) begin
      miscompares++;
      $display("FAIL lowest_idx: hit=%b idx=%0d len=%0d, required 1 1 3", r_hit, r_idx, r_len);
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] k;
    logic [22:0] snap;
    k = IW'($urandom_range(0, NE - 1));
    pkt_q.delete();
    for (int i = 0; i < 5; i++) pkt_q.push_back(8'($urandom));
    clear_mon();
    send_packet(32'd1 << k, 0);
    get_result(0);
    // get_result already completed one handshake; run a second packet and stall it
    pkt_q.delete();
    for (int i = 0; i < 6; i++) pkt_q.push_back(8'($urandom));
    send_packet(32'd1 << k, 0);
    for (int b = 0; b < 300 && res_valid !== 1'b1; b++) @(negedge clk);
    snap = {res_hit, res_idx, res_len, res_err};
    vectors++;
    if ({res_valid, snap} !== {1'b1, 1'b1, k, 16'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_result: valid=%b hit=%b idx=%0d len=%0d err=%b, required 1 1 %0d 6 0",
               res_valid, res_hit, res_idx, res_len, res_err, k);
    end
    in_valid = 1'b1; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({res_valid, in_ready, res_hit, res_idx, res_len, res_err} !== {1'b1, 1'b0, snap}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: valid=%b in_ready=%b res=%h, required 1 0 %h",
                 c, res_valid, in_ready, {res_hit, res_idx, res_len, res_err}, snap);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    vectors++;
    if ({res_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: res_valid=%b in_ready=%b, required 0 1 (idle dropping non-sof beat)", res_valid, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sof_error();
    logic          h1, e1;
    logic [15:0]   l1;
    logic [7:0]    nb0, nb1;
    pkt_q.delete();
    for (int i = 0; i < 3; i++) pkt_q.push_back(8'($urandom));
    nb0 = 8'($urandom); nb1 = 8'($urandom);
    clear_mon();
    eng_match = '0;
    send_beat(pkt_q[0], 1'b1, 1'b0);
    send_beat(pkt_q[1], 1'b0, 1'b0);
    send_beat(pkt_q[2], 1'b0, 1'b0);
    pkt_q.push_back(nb0);
    pkt_q.push_back(nb1);
    fork
      begin
        send_beat(nb0, 1'b1, 1'b0);
        send_beat(nb1, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        eng_match = 32'h0000_0004;
      end
      begin
        get_result(1);
        h1 = r_hit; l1 = r_len; e1 = r_err;
      end
    join
    get_result(0);
    vectors++;
    if ({h1, l1, e1} !== {1'b0, 16'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL sof_err_result: hit=%b len=%0d err=%b, required 0 3 1", h1, l1, e1);
    end
    vectors++;
    if ({r_hit, r_idx, r_len, r_err} !== {1'b1, 5'd2, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL sof_err_next: hit=%b idx=%0d len=%0d err=%b, required 1 2 2 0", r_hit, r_idx, r_len, r_err);
    end
    vectors++;
    if (sods !== 2) begin miscompares++; $display("FAIL sof_err_sod: pulses=%0d, required 2", sods); end
    vectors++;
    if (char_diffs() !== 0) begin miscompares++; $display("FAIL sof_err_chars: diffs=%0d, required 0", char_diffs()); end
    vectors++;
    if (flushes !== 2 * DC) begin miscompares++; $display("FAIL sof_err_flush: cycles=%0d, required %0d", flushes, 2 * DC); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    eng_match = '0;
    send_beat(8'h11, 1'b1, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    rst = 1'b1;
    rv_seen = 0;
    @(negedge clk);
    vectors++;
    if ({eng_sod, eng_en, res_valid, in_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_mid: sod=%b en=%b res_valid=%b in_ready=%b, required 1 0 0 0", eng_sod, eng_en, res_valid, in_ready);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (rv_seen !== 0) begin miscompares++; $display("FAIL rst_no_result: res_valid cycles=%0d, required 0", rv_seen); end
    pkt_q = '{8'h33, 8'h44, 8'h55};
    clear_mon();
    send_packet(32'h0, 0);
    get_result(0);
    vectors++;
    if ({r_hit, r_len, r_err} !== {1'b0, 16'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_next_pkt: hit=%b len=%0d err=%b, required 0 3 0", r_hit, r_len, r_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    int n;
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 24);
      case ($urandom_range(0, 2))
        0:       m = 32'h0;
        1:       m = 32'd1 << $urandom_range(0, 31);
        default: m = $urandom;
      endcase
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
      clear_mon();
      if ($urandom_range(0, 1) == 1) begin
        send_beat(8'($urandom), 1'b0, 1'b0);
        idle_gap($urandom_range(1, 2));
      end
      send_packet(m, 2);
      get_result($urandom_range(0, 3));
      vectors++;
      if ({r_hit, r_idx, r_len, r_err} !== {m != 0, ref_idx(m), 16'(n), 1'b0}) begin
        miscompares++;
        $display("FAIL rand_result pkt %0d: hit=%b idx=%0d len=%0d err=%b, required %b %0d %0d 0",
                 p, r_hit, r_idx, r_len, r_err, m != 0, ref_idx(m), n);
      end
      vectors++;
      if (char_diffs() !== 0) begin miscompares++; $display("FAIL rand_chars pkt %0d: diffs=%0d, required 0", p, char_diffs()); end
      vectors++;
      if ({sods, flushes} !== {32'd1, 32'(DC)}) begin
        miscompares++;
        $display("FAIL rand_framing pkt %0d: sod=%0d flush=%0d, required 1 %0d", p, sods, flushes, DC);
      end
      vectors++;
      if (excl_viol !== 0) begin miscompares++; $display("FAIL rand_sod_en pkt %0d: overlaps=%0d, required 0", p, excl_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_abcd();
    test_single();
    test_lowest_idx();
    test_backpressure();
    test_sof_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
